sigma_cpu: RTL and testbench
============================

Name: sigma_cpu

Overview:
- Small multi-cycle 32-bit CPU executing a subset of the XDS Sigma instruction set from one word-addressed memory.
- Memory read is combinational; memory write is registered with per-byte enables.
- Sits between the simulation memory model and the bench.
- Exposes opcode, program counter, instruction register, trap and instruction-end status for the bench to monitor.
- All buses use big-endian bit numbering: bit 0 is the MSB.

Parameters:
- RESET_PC, 17'h00000: word address of the first instruction fetched after reset.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset. It is sampled on the rising edge of clock.
- active  in  1  run enable. When 0, all state is held and mem_write_en is 0.
- memory_data_in  in  [0:31]  read data from memory; valid in the same cycle as memory_address.
- memory_address  out  [15:31]  17-bit word address.
- memory_data_out  out  [0:31]  write data.
- mem_write_en  out  [0:3]  byte write enables. Bit 0 selects byte [0:7].
- o  out  [0:6]  opcode of the current instruction.
- p  out  [15:31]  program counter, pointing to the next instruction word.
- q  out  [15:31]  address of the current instruction.
- c  out  [0:31]  current instruction register.
- trap  out  1  high and held once an unimplemented opcode is decoded.
- ende  out  1  one-cycle pulse in the final (EXEC) cycle of every completed instruction.

Behaviour:
- Instruction format:
  - bit 0 = indirect (I).
  - [1:7] = opcode.
  - [8:11] = R.
  - [12:14] = X (index register 1-7; 0 means no indexing).
  - [15:31] = reference address.
- Registers: 16 x 32-bit general registers R0-R15 and a 4-bit condition code CC[1:4].
- Reset: on a clock edge with reset=0:
  - P=RESET_PC; Q=0; C=0; o=0; all registers and CC =0.
  - trap=0; ende=0; state=FETCH; mem_write_en=0.
- FSM, each state takes one cycle:
  - FETCH: memory_address=P; C<=memory_data_in; o<=memory_data_in[1:7]; Q<=P; P<=P+1 (17-bit wrap). Next state is DECODE.
  - DECODE: immediate ops (LI, AI) go to EXEC. Otherwise, if I=1, go to INDIRECT; else EA=address+(X?R[X][15:31]:0) and go to EXEC. Unimplemented opcode: trap<=1 and go to HALT.
  - INDIRECT: memory_address=C[15:31]; EA=memory_data_in[15:31]+index (post-indexing). Next state is EXEC.
  - EXEC: perform the operation; ende=1; next state is FETCH, or HALT for WAIT.
  - HALT: terminal. Only reset leaves it; o keeps its last value.
- Latency: 3 cycles per instruction; indirect adds 1 cycle.
- Opcodes (hex):
  - 22 LI: R <= sign-extend C[12:31].
  - 20 AI: R <= R + sign-extend C[12:31].
  - 32 LW: R <= M[EA].
  - 35 STW: M[EA] <= R, with mem_write_en=4'b1111 during EXEC only.
  - 30 AW: R <= R + M[EA].
  - 38 SW: R <= R - M[EA].
  - 31 CW: compare R with M[EA]; CC only, no register write.
  - 4B AND, 49 OR, 48 EOR: R <= R op M[EA].
  - 68 BCR: branch to EA if (CC & R)==0.
  - 69 BCS: branch to EA if (CC & R)!=0.
  - 6A BAL: R <= P (zero-extended) and P <= EA. If R equals the index register, the index value used is the value from before the write.
  - 2E WAIT: stop in HALT.
- Condition code for all arithmetic, load and logical ops:
  - CC3 = result > 0; CC4 = result < 0 (signed); both 0 when result is zero.
  - CC2 = signed overflow for AI, AW, SW; otherwise CC2 is cleared.
  - CW sets CC3/CC4 from the sign of R - M.
  - CC1 = carry-out for AI/AW, and no-borrow (carry-out of R + ~M + 1) for SW; otherwise CC1 is cleared.
- Arithmetic: 32-bit two's complement; results wrap.
- mem_write_en is 0 in all other cycles; memory_data_out = R[R] during STW EXEC, otherwise 0.
- active=0 mid-instruction: the FSM freezes in its current state and resumes unchanged. ende and writes are suppressed while frozen.
- Reset has priority over active and over all states, including HALT and a trap.

Test Plan:
- Reset/fetch: hold reset=0 for 2 cycles, then release with active=1 and M[0]=LI R1,5 (0x22100005) -> first fetch address 0; R1=5; CC=0010; ende pulses at cycle 3; p=1.
- Arithmetic and overflow: LI R2,0x7FFFF; AI R2,1 -> R2=0x00080000, CC3=1. Then LW R3 from a word holding 0x7FFFFFFF and AI R3,1 -> R3=0x80000000; CC2=1; CC4=1.
- Memory access: STW R1,0x100; LW R4,0x100 -> write with enables 1111 at word 0x100; R4=5. Indirect LW with M[0x101]=0x00000100 -> R5=5, and the instruction takes 4 cycles.
- Branch: CW R1 against M=5, then BCR 0xC -> taken; BCS 0xC -> not taken. BAL R6,0x40 -> R6=return address; p=0x40.
- WAIT/trap: WAIT at word 0x10 -> o=0x2E, FSM halts, q=0x10. Opcode 0x7F -> trap=1 with q pointing at that word, and no further fetches.
- Stall: drop active for 3 cycles mid-LW -> completion is delayed by exactly 3 cycles with no extra ende pulses.

Source files
------------

// File: rtl/sigma_cpu.sv
// sigma_cpu: small multi-cycle 32-bit CPU running a subset of the XDS Sigma
// instruction set out of a single word-addressed memory. Memory reads are
// combinational; memory writes are registered in the memory with byte enables.
// All buses use big-endian bit numbering (bit 0 is the MSB).
//
// Ports:
//   clock           system clock, rising-edge
//   reset           synchronous active-low reset
//   active          run enable; 0 freezes all state and suppresses writes/ende
//   memory_data_in  [0:31]  combinational read data for memory_address
//   memory_address  [15:31] word address
//   memory_data_out [0:31]  store data (R[R] during STW EXEC, else 0)
//   mem_write_en    [0:3]   byte enables, bit 0 selects byte [0:7]
//   o               [0:6]   opcode of the current instruction
//   p               [15:31] address of the next instruction word
//   q               [15:31] address of the current instruction
//   c               [0:31]  current instruction register
//   trap            sticky, set when an unimplemented opcode is decoded
//   ende            one-cycle pulse in the EXEC cycle of each instruction
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read M[P] into C/o, Q <= P, P <= P+1
// DECODE   | compute EA directly, or route to INDIRECT/EXEC, or trap
// INDIRECT | read pointer word at C[15:31], EA = pointer + index
// EXEC     | perform the operation, pulse ende
// HALT     | terminal (WAIT or trap); only reset leaves it

module sigma_cpu #(
  parameter logic [15:31] RESET_PC = 17'h00000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          active,
  input  logic [0:31]   memory_data_in,
  output logic [15:31]  memory_address,
  output logic [0:31]   memory_data_out,
  output logic [0:3]    mem_write_en,
  output logic [0:6]    o,
  output logic [15:31]  p,
  output logic [15:31]  q,
  output logic [0:31]   c,
  output logic          trap,
  output logic          ende
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_INDIRECT = 3'd2,
    S_EXEC     = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  localparam logic [0:6] OP_LI   = 7'h22;
  localparam logic [0:6] OP_AI   = 7'h20;
  localparam logic [0:6] OP_LW   = 7'h32;
  localparam logic [0:6] OP_STW  = 7'h35;
  localparam logic [0:6] OP_AW   = 7'h30;
  localparam logic [0:6] OP_SW   = 7'h38;
  localparam logic [0:6] OP_CW   = 7'h31;
  localparam logic [0:6] OP_AND  = 7'h4B;
  localparam logic [0:6] OP_OR   = 7'h49;
  localparam logic [0:6] OP_EOR  = 7'h48;
  localparam logic [0:6] OP_BCR  = 7'h68;
  localparam logic [0:6] OP_BCS  = 7'h69;
  localparam logic [0:6] OP_BAL  = 7'h6A;
  localparam logic [0:6] OP_WAIT = 7'h2E;

  state_t        state_q, state_d;
  logic [15:31]  p_q, p_d;
  logic [15:31]  q_q, q_d;
  logic [0:31]   c_q, c_d;
  logic [0:6]    o_q, o_d;
  logic [15:31]  ea_q, ea_d;
  logic [1:4]    cc_q, cc_d;
  logic          trap_q, trap_d;
  logic [0:31]   regs_q [0:15];
  logic [0:31]   regs_d [0:15];

  logic          ind;
  logic [0:3]    r_idx;
  logic [0:2]    x_idx;
  logic [15:31]  ref_addr;
  logic [15:31]  index_val;
  logic [0:31]   r_val;
  logic [0:31]   imm;

  logic [0:31]   add_b;
  logic          add_cin;
  logic [0:32]   add_full;
  logic [0:31]   add_sum;
  logic          add_carry;
  logic          add_ovf;

  function automatic logic [0:1] sign_flags(input logic [0:31] v);
    // {CC3, CC4}: strictly positive, negative
    return {(~v[0]) & (v != 32'h0), v[0]};
  endfunction

  function automatic logic implemented(input logic [0:6] op);
    case (op)
      OP_LI, OP_AI, OP_LW, OP_STW, OP_AW, OP_SW, OP_CW,
      OP_AND, OP_OR, OP_EOR, OP_BCR, OP_BCS, OP_BAL, OP_WAIT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign ind      = c_q[0];
  assign r_idx    = c_q[8:11];
  assign x_idx    = c_q[12:14];
  assign ref_addr = c_q[15:31];
  assign r_val    = regs_q[r_idx];
  assign imm      = {{12{c_q[12]}}, c_q[12:31]};

  // Only the low 17 bits of the index register take part in the address.
  assign index_val = (x_idx != 3'd0) ? regs_q[{1'b0, x_idx}][15:31] : 17'h0;

  // Shared adder: AI/AW add, SW/CW compute R + ~M + 1 so carry-out is the
  // no-borrow flag.
  always_comb begin
    add_b   = memory_data_in;
    add_cin = 1'b0;
    if (o_q == OP_AI) begin
      add_b = imm;
    end else if (o_q == OP_SW || o_q == OP_CW) begin
      add_b   = ~memory_data_in;
      add_cin = 1'b1;
    end
    add_full  = {1'b0, r_val} + {1'b0, add_b} + {32'h0, add_cin};
    add_carry = add_full[0];
    add_sum   = add_full[1:32];
    add_ovf   = (r_val[0] == add_b[0]) && (add_sum[0] != r_val[0]);
  end

  always_comb begin
    state_d         = state_q;
    p_d             = p_q;
    q_d             = q_q;
    c_d             = c_q;
    o_d             = o_q;
    ea_d            = ea_q;
    cc_d            = cc_q;
    trap_d          = trap_q;
    regs_d          = regs_q;
    memory_address  = ea_q;
    memory_data_out = 32'h0;
    mem_write_en    = 4'b0000;
    ende            = 1'b0;

    case (state_q)
      S_FETCH:    memory_address = p_q;
      S_INDIRECT: memory_address = c_q[15:31];
      default:    memory_address = ea_q;
    endcase

    if (state_q == S_EXEC && o_q == OP_STW) begin
      memory_data_out = r_val;
    end

    if (active) begin
      case (state_q)
        S_FETCH: begin
          c_d     = memory_data_in;
          o_d     = memory_data_in[1:7];
          q_d     = p_q;
          p_d     = p_q + 17'd1;
          state_d = S_DECODE;
        end

        S_DECODE: begin
          if (!implemented(o_q)) begin
            trap_d  = 1'b1;
            state_d = S_HALT;
          end else if (o_q == OP_LI || o_q == OP_AI) begin
            state_d = S_EXEC;
          end else if (ind) begin
            state_d = S_INDIRECT;
          end else begin
            ea_d    = ref_addr + index_val;
            state_d = S_EXEC;
          end
        end

        S_INDIRECT: begin
          ea_d    = memory_data_in[15:31] + index_val;
          state_d = S_EXEC;
        end

        S_EXEC: begin
          ende    = 1'b1;
          state_d = S_FETCH;
          case (o_q)
            OP_LI: begin
              regs_d[r_idx] = imm;
              cc_d          = {2'b00, sign_flags(imm)};
            end
            OP_AI, OP_AW, OP_SW: begin
              regs_d[r_idx] = add_sum;
              cc_d          = {add_carry, add_ovf, sign_flags(add_sum)};
            end
            OP_LW: begin
              regs_d[r_idx] = memory_data_in;
              cc_d          = {2'b00, sign_flags(memory_data_in)};
            end
            OP_STW: begin
              mem_write_en = 4'b1111;
            end
            OP_CW: begin
              cc_d = {2'b00, sign_flags(add_sum)};
            end
            OP_AND: begin
              regs_d[r_idx] = r_val & memory_data_in;
              cc_d          = {2'b00, sign_flags(r_val & memory_data_in)};
            end
            OP_OR: begin
              regs_d[r_idx] = r_val | memory_data_in;
              cc_d          = {2'b00, sign_flags(r_val | memory_data_in)};
            end
            OP_EOR: begin
              regs_d[r_idx] = r_val ^ memory_data_in;
              cc_d          = {2'b00, sign_flags(r_val ^ memory_data_in)};
            end
            OP_BCR: begin
              if ((cc_q & r_idx) == 4'b0000) p_d = ea_q;
            end
            OP_BCS: begin
              if ((cc_q & r_idx) != 4'b0000) p_d = ea_q;
            end
            OP_BAL: begin
              // EA was latched earlier, so an index register that is also
              // the link register contributes its old value.
              regs_d[r_idx] = {15'h0, p_q};
              p_d           = ea_q;
            end
            OP_WAIT: begin
              state_d = S_HALT;
            end
            default: begin
            end
          endcase
        end

        S_HALT: begin
        end

        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_FETCH;
      p_q     <= RESET_PC;
      q_q     <= 17'h0;
      c_q     <= 32'h0;
      o_q     <= 7'h0;
      ea_q    <= 17'h0;
      cc_q    <= 4'h0;
      trap_q  <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      c_q     <= c_d;
      o_q     <= o_d;
      ea_q    <= ea_d;
      cc_q    <= cc_d;
      trap_q  <= trap_d;
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign o    = o_q;
  assign p    = p_q;
  assign q    = q_q;
  assign c    = c_q;
  assign trap = trap_q;

endmodule

// File: tb/tb_sigma_cpu.sv
module tb_sigma_cpu;

  logic          clock;
  logic          reset;
  logic          active;
  logic [0:31]   memory_data_in;
  logic [15:31]  memory_address;
  logic [0:31]   memory_data_out;
  logic [0:3]    mem_write_en;
  logic [0:6]    o;
  logic [15:31]  p;
  logic [15:31]  q;
  logic [0:31]   c;
  logic          trap;
  logic          ende;

  int checks = 0;
  int errors = 0;

  logic [0:31]   mem [0:4095];
  logic [0:3]    last_we;
  logic [15:31]  last_addr;
  logic [0:31]   last_dout;

  sigma_cpu #(.RESET_PC(17'h00000)) dut (
    .clock(clock),
    .reset(reset),
    .active(active),
    .memory_data_in(memory_data_in),
    .memory_address(memory_address),
    .memory_data_out(memory_data_out),
    .mem_write_en(mem_write_en),
    .o(o),
    .p(p),
    .q(q),
    .c(c),
    .trap(trap),
    .ende(ende)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign memory_data_in = mem[memory_address[20:31]];

  always @(posedge clock) begin
    if (mem_write_en[0]) mem[memory_address[20:31]][0:7]   <= memory_data_out[0:7];
    if (mem_write_en[1]) mem[memory_address[20:31]][8:15]  <= memory_data_out[8:15];
    if (mem_write_en[2]) mem[memory_address[20:31]][16:23] <= memory_data_out[16:23];
    if (mem_write_en[3]) mem[memory_address[20:31]][24:31] <= memory_data_out[24:31];
  end

  function automatic logic [0:31] enc(input logic ind, input logic [6:0] op,
                                      input logic [3:0] r, input logic [2:0] x,
                                      input logic [16:0] a);
    return {ind, op, r, x, a};
  endfunction

  function automatic logic [0:31] enc_imm(input logic [6:0] op, input logic [3:0] r,
                                          input logic [19:0] imm);
    return {1'b0, op, r, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle to the edge after its EXEC
  // cycle, optionally dropping active for stall_len cycles after cycle stall_at.
  task automatic run_instr(input string tag, input int exp_cycles,
                           input int stall_at, input int stall_len);
    int   cyc;
    logic seen;
    int   stray_we;
    cyc = 0; seen = 1'b0; stray_we = 0;
    while (!seen && cyc < 30) begin
      @(negedge clock);
      cyc++;
      if (ende) begin
        seen      = 1'b1;
        last_we   = mem_write_en;
        last_addr = memory_address;
        last_dout = memory_data_out;
      end else begin
        if (mem_write_en != 4'b0000) stray_we++;
        if (stall_len > 0 && cyc == stall_at) active = 1'b0;
        if (stall_len > 0 && cyc == stall_at + stall_len) active = 1'b1;
      end
    end
    active = 1'b1;
    chk({tag, "_ende"}, {31'h0, seen}, 32'h1);
    chk({tag, "_cycles"}, cyc, exp_cycles);
    chk({tag, "_stray_we"}, stray_we, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int ende_cnt;
    reset  = 1'b0;
    active = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

    mem[12'h000] = enc_imm(7'h22, 4'd1, 20'h00005);            // LI R1,5
    mem[12'h001] = enc_imm(7'h22, 4'd2, 20'h7FFFF);            // LI R2,0x7FFFF
    mem[12'h002] = enc_imm(7'h20, 4'd2, 20'h00001);            // AI R2,1
    mem[12'h003] = enc(1'b0, 7'h32, 4'd3, 3'd0, 17'h200);      // LW R3,0x200
    mem[12'h004] = enc_imm(7'h20, 4'd3, 20'h00001);            // AI R3,1
    mem[12'h005] = enc(1'b0, 7'h35, 4'd1, 3'd0, 17'h100);      // STW R1,0x100
    mem[12'h006] = enc(1'b0, 7'h32, 4'd4, 3'd0, 17'h100);      // LW R4,0x100
    mem[12'h007] = enc(1'b1, 7'h32, 4'd5, 3'd0, 17'h101);      // LW R5,*0x101
    mem[12'h008] = enc(1'b0, 7'h31, 4'd1, 3'd0, 17'h102);      // CW R1,0x102
    mem[12'h009] = enc(1'b0, 7'h68, 4'hC, 3'd0, 17'h00B);      // BCR 0xC,0x0B
    mem[12'h00A] = enc_imm(7'h22, 4'd7, 20'h00111);            // LI R7 (skipped)
    mem[12'h00B] = enc(1'b0, 7'h69, 4'hC, 3'd0, 17'h030);      // BCS 0xC,0x30
    mem[12'h00C] = enc(1'b0, 7'h6A, 4'd6, 3'd0, 17'h040);      // BAL R6,0x40
    mem[12'h010] = enc(1'b0, 7'h2E, 4'd0, 3'd0, 17'h000);      // WAIT
    mem[12'h040] = enc(1'b0, 7'h30, 4'd2, 3'd0, 17'h201);      // AW R2,0x201
    mem[12'h041] = enc(1'b0, 7'h38, 4'd4, 3'd0, 17'h102);      // SW R4,0x102
    mem[12'h042] = enc(1'b0, 7'h4B, 4'd3, 3'd0, 17'h203);      // AND R3,0x203
    mem[12'h043] = enc(1'b0, 7'h49, 4'd1, 3'd0, 17'h204);      // OR R1,0x204
    mem[12'h044] = enc(1'b0, 7'h48, 4'd1, 3'd0, 17'h205);      // EOR R1,0x205
    mem[12'h045] = enc(1'b0, 7'h32, 4'd8, 3'd6, 17'h1F3);      // LW R8,0x1F3,6
    mem[12'h046] = enc(1'b0, 7'h32, 4'd9, 3'd0, 17'h100);      // LW R9,0x100
    mem[12'h047] = enc_imm(7'h22, 4'd10, 20'hFFFFF);           // LI R10,-1
    mem[12'h048] = enc(1'b0, 7'h6A, 4'd6, 3'd6, 17'h003);      // BAL R6,0x03,6
    mem[12'h101] = 32'h0000_0100;
    mem[12'h102] = 32'h0000_0005;
    mem[12'h200] = 32'h7FFF_FFFF;
    mem[12'h201] = 32'hFFFF_FFFF;
    mem[12'h203] = 32'hF000_0000;
    mem[12'h204] = 32'h0000_0030;
    mem[12'h205] = 32'h0000_0035;

    do_reset();
    chk("rst_p", {15'h0, p}, 32'h0);
    chk("rst_q", {15'h0, q}, 32'h0);
    chk("rst_c", c, 32'h0);
    chk("rst_o", {25'h0, o}, 32'h0);
    chk("rst_trap", {31'h0, trap}, 32'h0);
    chk("rst_ende", {31'h0, ende}, 32'h0);
    chk("rst_we", {28'h0, mem_write_en}, 32'h0);
    reset = 1'b1;
    chk("fetch_addr0", {15'h0, memory_address}, 32'h0);

    run_instr("li_r1", 3, 0, 0);
    chk("li_r1_val", dut.regs_q[1], 32'h5);
    chk("li_r1_cc", {28'h0, dut.cc_q}, 32'h2);
    chk("li_r1_p", {15'h0, p}, 32'h1);

    run_instr("li_r2", 3, 0, 0);
    chk("li_r2_val", dut.regs_q[2], 32'h0007_FFFF);
    run_instr("ai_r2", 3, 0, 0);
    chk("ai_r2_val", dut.regs_q[2], 32'h0008_0000);
    chk("ai_r2_cc", {28'h0, dut.cc_q}, 32'h2);

    run_instr("lw_r3", 3, 0, 0);
    chk("lw_r3_val", dut.regs_q[3], 32'h7FFF_FFFF);
    run_instr("ai_r3", 3, 0, 0);
    chk("ai_r3_val", dut.regs_q[3], 32'h8000_0000);
    chk("ai_r3_cc", {28'h0, dut.cc_q}, 32'h5);

    run_instr("stw", 3, 0, 0);
    chk("stw_we", {28'h0, last_we}, 32'hF);
    chk("stw_addr", {15'h0, last_addr}, 32'h100);
    chk("stw_dout", last_dout, 32'h5);
    chk("stw_mem", mem[12'h100], 32'h5);
    chk("stw_cc", {28'h0, dut.cc_q}, 32'h5);

    run_instr("lw_r4", 3, 0, 0);
    chk("lw_r4_val", dut.regs_q[4], 32'h5);
    run_instr("lw_ind", 4, 0, 0);
    chk("lw_ind_val", dut.regs_q[5], 32'h5);

    run_instr("cw", 3, 0, 0);
    chk("cw_cc", {28'h0, dut.cc_q}, 32'h0);
    chk("cw_r1", dut.regs_q[1], 32'h5);
    run_instr("bcr", 3, 0, 0);
    chk("bcr_p", {15'h0, p}, 32'h0B);
    run_instr("bcs", 3, 0, 0);
    chk("bcs_p", {15'h0, p}, 32'h0C);
    chk("skip_r7", dut.regs_q[7], 32'h0);
    run_instr("bal", 3, 0, 0);
    chk("bal_r6", dut.regs_q[6], 32'h0D);
    chk("bal_p", {15'h0, p}, 32'h40);

    run_instr("aw", 3, 0, 0);
    chk("aw_val", dut.regs_q[2], 32'h0007_FFFF);
    chk("aw_cc", {28'h0, dut.cc_q}, 32'hA);
    run_instr("sw", 3, 0, 0);
    chk("sw_val", dut.regs_q[4], 32'h0);
    chk("sw_cc", {28'h0, dut.cc_q}, 32'h8);
    run_instr("and", 3, 0, 0);
    chk("and_val", dut.regs_q[3], 32'h8000_0000);
    chk("and_cc", {28'h0, dut.cc_q}, 32'h1);
    run_instr("or", 3, 0, 0);
    chk("or_val", dut.regs_q[1], 32'h35);
    chk("or_cc", {28'h0, dut.cc_q}, 32'h2);
    run_instr("eor", 3, 0, 0);
    chk("eor_val", dut.regs_q[1], 32'h0);
    chk("eor_cc", {28'h0, dut.cc_q}, 32'h0);
    run_instr("lw_idx", 3, 0, 0);
    chk("lw_idx_val", dut.regs_q[8], 32'h7FFF_FFFF);

    run_instr("lw_stall", 6, 2, 3);
    chk("lw_stall_val", dut.regs_q[9], 32'h5);
    run_instr("li_neg", 3, 0, 0);
    chk("li_neg_val", dut.regs_q[10], 32'hFFFF_FFFF);
    chk("li_neg_cc", {28'h0, dut.cc_q}, 32'h1);

    run_instr("bal_self", 3, 0, 0);
    chk("bal_self_r6", dut.regs_q[6], 32'h49);
    chk("bal_self_p", {15'h0, p}, 32'h10);

    run_instr("wait", 3, 0, 0);
    ende_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (ende) ende_cnt++;
    end
    chk("wait_ende_cnt", ende_cnt, 0);
    chk("wait_o", {25'h0, o}, 32'h2E);
    chk("wait_q", {15'h0, q}, 32'h10);
    chk("wait_p", {15'h0, p}, 32'h11);

    mem[12'h000] = enc(1'b0, 7'h7F, 4'd0, 3'd0, 17'h000);
    do_reset();
    chk("rst2_p", {15'h0, p}, 32'h0);
    chk("rst2_o", {25'h0, o}, 32'h0);
    reset = 1'b1;
    ende_cnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (ende) ende_cnt++;
    end
    chk("trap_flag", {31'h0, trap}, 32'h1);
    chk("trap_q", {15'h0, q}, 32'h0);
    chk("trap_o", {25'h0, o}, 32'h7F);
    chk("trap_p", {15'h0, p}, 32'h1);
    chk("trap_ende_cnt", ende_cnt, 0);

    do_reset();
    chk("rst3_trap", {31'h0, trap}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
